// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
//   DIGIT_COUNT    : number of multiplexed digits on the display
//   SEG_BLANK      : active-low "all segments off" pattern
//   HEX_SEG_TABLE  : active-low {g,f,e,d,c,b,a} pattern per hex nibble,
//                    element i holds the pattern for nibble value i
//   shadow_t       : per-frame copy of the digit data and masks
package seg_scan_driver_pkg;

    localparam int DIGIT_COUNT = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef struct packed {
        logic [4*DIGIT_COUNT-1:0] digits;
        logic [DIGIT_COUNT-1:0]   blank;
        logic [DIGIT_COUNT-1:0]   blink;
        logic [DIGIT_COUNT-1:0]   dp;
    } shadow_t;

    // Out of reset every digit is blanked so nothing lights until a full
    // frame of real data has been captured.
    localparam shadow_t SHADOW_RESET = '{
        digits: '0,
        blank:  '1,
        blink:  '0,
        dp:     '0
    };

endpackage

// File: rtl/seg_scan_driver_seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : active-low segments, seg[0]=a .. seg[6]=g
module seg7_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
//   master_clock : system clock, all state on its rising edge
//   rst          : synchronous active-high reset
//   clk_fast     : asynchronous scan clock level; each rising edge advances the digit
//   clk_blink    : asynchronous blink clock level; low phase darkens blinking digits
//   digits       : four hex nibbles, digit i = digits[4i+3:4i]
//   blank_mask   : bit i forces digit i dark
//   blink_mask   : bit i darkens digit i while the blink phase is low
//   dp_mask      : bit i lights the decimal point of digit i
//   an           : active-low anode enables
//   seg          : active-low segments, seg[0]=a .. seg[6]=g
//   dp           : active-low decimal point
//   scan_tick    : one-cycle strobe in the cycle a new digit index first shows
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        master_clock,
    input  logic        rst,
    input  logic        clk_fast,
    input  logic        clk_blink,
    input  logic [15:0] digits,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        scan_tick
);

    logic [SYNC_STAGES-1:0] fast_sync;
    logic [SYNC_STAGES-1:0] blink_sync;
    logic                   fast_prev;

    logic [1:0] idx;
    logic [3:0] guard;
    shadow_t    shadow;

    logic       tick;
    logic       blink_phase;
    logic [1:0] idx_nxt;
    logic [3:0] guard_nxt;
    shadow_t    shadow_nxt;
    logic [3:0] nibble;
    logic [6:0] seg_dec;
    logic       dark;
    logic [3:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    // Synchronised levels and rising-edge detect
    assign tick        = fast_sync[SYNC_STAGES-1] & ~fast_prev;
    assign blink_phase = blink_sync[SYNC_STAGES-1];

    // Next scan state. The outputs are registered from these next values so
    // that an/seg/dp switch in the same cycle the index register does.
    always_comb begin
        idx_nxt    = idx;
        shadow_nxt = shadow;
        guard_nxt  = (guard != 4'd0) ? guard - 4'd1 : 4'd0;
        if (tick) begin
            idx_nxt   = idx + 2'd1;
            guard_nxt = 4'(BLANK_CYCLES);
            // New data is only taken at a frame boundary so a frame never
            // mixes old and new digits.
            if (idx == 2'd3) begin
                shadow_nxt.digits = digits;
                shadow_nxt.blank  = blank_mask;
                shadow_nxt.blink  = blink_mask;
                shadow_nxt.dp     = dp_mask;
            end
        end
    end

    assign nibble = shadow_nxt.digits[{idx_nxt, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_comb begin
        dark    = shadow_nxt.blank[idx_nxt] | (shadow_nxt.blink[idx_nxt] & ~blink_phase);
        an_nxt  = 4'hF;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        if (!dark) begin
            seg_nxt = seg_dec;
            dp_nxt  = ~shadow_nxt.dp[idx_nxt];
            // Anodes stay off during the guard interval while segments settle.
            if (guard_nxt == 4'd0) begin
                an_nxt = ~(4'b0001 << idx_nxt);
            end
        end
    end

    // State and output registers
    always_ff @(posedge master_clock) begin
        if (rst) begin
            fast_sync  <= '0;
            blink_sync <= '0;
            fast_prev  <= 1'b0;
            idx        <= 2'd0;
            guard      <= 4'd0;
            shadow     <= SHADOW_RESET;
            an         <= 4'hF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            scan_tick  <= 1'b0;
        end else begin
            fast_sync  <= {fast_sync[SYNC_STAGES-2:0], clk_fast};
            blink_sync <= {blink_sync[SYNC_STAGES-2:0], clk_blink};
            fast_prev  <= fast_sync[SYNC_STAGES-1];
            idx        <= idx_nxt;
            guard      <= guard_nxt;
            shadow     <= shadow_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            scan_tick  <= tick;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised self-checking bench for seg_scan_driver with a cycle-level
// reference model built from input sample histories.
module tb_seg_scan_driver;

    localparam int SYNC_STAGES  = 2;
    localparam int BLANK_CYCLES = 2;
    localparam int MAXCYC       = 20000;

    logic        master_clock = 1'b0;
    logic        rst          = 1'b1;
    logic        clk_fast     = 1'b0;
    logic        clk_blink    = 1'b0;
    logic [15:0] digits       = 16'h0;
    logic [3:0]  blank_mask   = 4'h0;
    logic [3:0]  blink_mask   = 4'h0;
    logic [3:0]  dp_mask      = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        scan_tick;

    seg_scan_driver #(
        .SYNC_STAGES  (SYNC_STAGES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .master_clock (master_clock),
        .rst          (rst),
        .clk_fast     (clk_fast),
        .clk_blink    (clk_blink),
        .digits       (digits),
        .blank_mask   (blank_mask),
        .blink_mask   (blink_mask),
        .dp_mask      (dp_mask),
        .an           (an),
        .seg          (seg),
        .dp           (dp),
        .scan_tick    (scan_tick)
    );

    always #5 master_clock = ~master_clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Standard hex glyphs, active-low {g..a}
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: histories of what the DUT sampled on each edge.
    bit fast_hist  [MAXCYC];
    bit blink_hist [MAXCYC];
    int cyc       = -1;
    int rst_edge  = -1;
    bit model_ok  = 0;

    int          m_pos;
    int          m_guard;
    logic [15:0] m_digits;
    logic [3:0]  m_blank, m_blink, m_dp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_tick;
    int          tick_count = 0;

    // Level the synchroniser had delivered from the sample taken at edge e.
    function automatic bit seen_fast(int e);
        return (e > rst_edge && e >= 0) ? fast_hist[e] : 1'b0;
    endfunction
    function automatic bit seen_blink(int e);
        return (e > rst_edge && e >= 0) ? blink_hist[e] : 1'b0;
    endfunction

    task automatic model_update();
        bit step, phase, lit;
        cyc++;
        fast_hist[cyc]  = clk_fast;
        blink_hist[cyc] = clk_blink;
        if (rst) begin
            rst_edge = cyc;
            model_ok = 1;
            m_pos = 0; m_guard = 0;
            m_digits = 16'h0; m_blank = 4'hF; m_blink = 4'h0; m_dp = 4'h0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
            return;
        end
        // A rising edge sampled at edge e moves the display at edge e+SYNC_STAGES.
        step  = seen_fast(cyc - SYNC_STAGES) && !seen_fast(cyc - SYNC_STAGES - 1);
        phase = seen_blink(cyc - SYNC_STAGES);
        if (step) begin
            if (m_pos == 3) begin
                m_digits = digits; m_blank = blank_mask;
                m_blink = blink_mask; m_dp = dp_mask;
            end
            m_pos   = (m_pos + 1) % 4;
            m_guard = BLANK_CYCLES;
        end else if (m_guard > 0) begin
            m_guard--;
        end
        lit    = !(m_blank[m_pos] || (m_blink[m_pos] && !phase));
        e_tick = step;
        e_an   = (lit && m_guard == 0) ? ~(4'b0001 << m_pos) : 4'hF;
        e_seg  = lit ? glyph[m_digits[4*m_pos +: 4]] : 7'h7F;
        e_dp   = lit ? ~m_dp[m_pos] : 1'b1;
    endtask

    task automatic step_cycle();
        @(posedge master_clock);
        model_update();
        @(negedge master_clock);
        if (model_ok) begin
            check("an", 32'(an), 32'(e_an));
            check("seg", 32'(seg), 32'(e_seg));
            check("dp", 32'(dp), 32'(e_dp));
            check("scan_tick", 32'(scan_tick), 32'(e_tick));
        end
        if (scan_tick === 1'b1) tick_count++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic fast_pulse();
        clk_fast = 1'b1; run(3);
        clk_fast = 1'b0; run(3);
    endtask

    int hi_left, lo_left, blink_left;
    logic [3:0] an_hold;

    initial begin
        // Reset state
        rst = 1'b1;
        run(3);
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'h1);
        check("reset_tick", 32'(scan_tick), 32'h0);
        rst = 1'b0;
        digits = 16'h1234;
        clk_blink = 1'b1;
        run(4);

        // First frame dark, then digits 4,3,2,1 after the wrap
        for (int k = 0; k < 3; k++) fast_pulse();
        check("first_frame_dark", 32'(an), 32'hF);
        fast_pulse();
        check("wrap_an0", 32'(an), 32'b1110);
        check("wrap_seg0", 32'(seg), 32'h19);
        fast_pulse();
        check("an1", 32'(an), 32'b1101);
        check("seg1", 32'(seg), 32'h30);
        // New data mid-frame only appears after the next wrap
        digits = 16'hABCD;
        fast_pulse();
        check("old_seg2", 32'(seg), 32'h24);
        fast_pulse();
        check("old_seg3", 32'(seg), 32'h79);
        fast_pulse();
        check("new_seg0", 32'(seg), 32'h21);

        // Blinking digit 0
        blink_mask = 4'b0001;
        for (int k = 0; k < 4; k++) fast_pulse();
        clk_blink = 1'b0; run(6);
        check("blink_low_dark", 32'(an), 32'hF);
        clk_blink = 1'b1; run(6);
        check("blink_high_lit", 32'(an), 32'b1110);

        // Reset coincident with a tick at index 2
        clk_fast = 1'b1; run(1);
        clk_fast = 1'b0; run(3);
        clk_fast = 1'b1; run(1);
        rst = 1'b1; run(1);
        rst = 1'b0;
        check("rst_tick_an", 32'(an), 32'hF);
        check("rst_tick_seg", 32'(seg), 32'h7F);
        check("rst_tick_strobe", 32'(scan_tick), 32'h0);
        clk_fast = 1'b0; run(4);

        // clk_fast stuck high: exactly one tick, anode steady
        tick_count = 0;
        clk_fast = 1'b1;
        run(20);
        an_hold = an;
        run(980);
        check("stuck_ticks", 32'(tick_count), 32'd1);
        check("stuck_anode", 32'(an), 32'(an_hold));
        clk_fast = 1'b0; run(4);

        // Randomised scanning with changing data, masks, blink and resets
        hi_left = 1; lo_left = 1; blink_left = 10;
        for (int i = 0; i < 4000; i++) begin
            if (clk_fast) begin
                if (--hi_left <= 0) begin clk_fast = 1'b0; lo_left = $urandom_range(1, 5); end
            end else begin
                if (--lo_left <= 0) begin clk_fast = 1'b1; hi_left = $urandom_range(1, 5); end
            end
            if (--blink_left <= 0) begin
                clk_blink = ~clk_blink;
                blink_left = $urandom_range(5, 40);
            end
            if ($urandom_range(0, 15) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 31) == 0) blank_mask = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) dp_mask = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 499) == 0);
            step_cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flops synchronising clk_fast and clk_blink into master_clock domain, legal range 2..3.
REQ-002 SHALL have parameter BLANK_CYCLES, default 2: anode-off guard cycles after each digit switch, legal range 0..15.
REQ-003 SHALL have port master_clock  in  1  system clock; all state on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port clk_fast  in  1  divided scan clock, treated as an asynchronous level.
REQ-006 SHALL have port clk_blink  in  1  divided blink clock, treated as an asynchronous level.
REQ-007 SHALL have port digits  in  16  four hex nibbles; digit i = digits[4i+3:4i], digit 0 rightmost.
REQ-008 SHALL have port blank_mask  in  4  bit i=1 forces digit i dark.
REQ-009 SHALL have port blink_mask  in  4  bit i=1 darkens digit i while blink phase is low.
REQ-010 SHALL have port dp_mask  in  4  bit i=1 lights the decimal point of digit i.
REQ-011 SHALL have port an  out  4  anode enables, active-low, an[i] selects digit i.
REQ-012 SHALL have port seg  out  7  segments, active-low, seg[0]=a .. seg[6]=g.
REQ-013 SHALL have port dp  out  1  decimal point, active-low.
REQ-014 SHALL have port scan_tick  out  1  one-cycle strobe, high in the cycle an/seg first show a new index.

Function
REQ-015 SHALL pass clk_fast and clk_blink through SYNC_STAGES flops each; blink phase = synchronised clk_blink level.
REQ-016 SHALL detect tick = synchronised clk_fast high AND its previous-cycle value low; falling edges are ignored.
REQ-017 SHALL keep a 2-bit scan index that increments on each tick, wrapping 3->0.
REQ-018 SHALL hold digits/blank_mask/blink_mask/dp_mask in a shadow register loaded only on the tick that wraps the index 3->0, so that a frame never mixes old and new data.
REQ-019 SHALL register an/seg/dp from index and shadow, so outputs change one cycle after the tick-detect edge, coincident with scan_tick.
REQ-020 SHALL, after each index change, drive an=4'b1111 for BLANK_CYCLES cycles, then drive an with only bit [index] low; BLANK_CYCLES=0 means no guard.
REQ-021 SHALL restart the guard counter when a tick arrives during a guard interval.
REQ-022 SHALL treat digit i as dark when shadow blank_mask[i]=1 or (shadow blink_mask[i]=1 and blink phase=0): an[i]=1, seg=7'h7F, dp=1.
REQ-023 SHALL decode nibbles 0-F to standard hex patterns (e.g. 0->7'h40, 8->7'h00, F->7'h0E with seg[6:0]={g..a}).
REQ-024 SHALL hold the current digit indefinitely if clk_fast stops toggling.
REQ-025 SHALL track blink-phase changes within one cycle of the synchronised level, independent of ticks.

Reset
REQ-026 SHALL, on rst, set index=0, guard counter=0, sync/edge flops=0, shadow digits=0, shadow blank_mask=4'hF, other shadow masks=0.
REQ-027 SHALL, on rst, set outputs to an=4'hF, seg=7'h7F, dp=1, scan_tick=0, with rst overriding any coincident tick.
REQ-028 SHALL, when reset is applied mid-frame, abandon the frame; the display stays dark until the first 3->0 wrap after reset.

Structure
REQ-029 SHALL place the hex-to-segment table, the active-low blank constant 7'h7F, and the digit count 4 in the shared game package.
REQ-030 SHALL instantiate one combinational sub-module seg7_decode (4-bit nibble in, 7-bit active-low segments out).

Verification
REQ-031 Reset then 4 clk_fast rising edges, digits=16'h1234, masks=0 -> dark for the first frame; after the 3->0 wrap, an cycles 1110,1101,1011,0111 showing 4,3,2,1.
REQ-032 BLANK_CYCLES=2: each scan_tick -> an=1111 for exactly 2 cycles, then the one-hot-low anode; seg valid throughout.
REQ-033 digits changed from 16'h1234 to 16'hABCD while index=1 -> digits 2,3 still show 2,1; A..D appear only after the next wrap.
REQ-034 blink_mask=4'b0001, clk_blink toggling -> digit 0 dark while blink phase low, lit while high; other digits unaffected.
REQ-035 rst pulsed for 1 cycle coincident with a tick at index=2 -> index=0, an=1111, seg=7'h7F, scan_tick=0 on the next cycle.
REQ-036 clk_fast held high for 1000 cycles -> exactly one scan_tick, index frozen, anode steady.
